// File: rtl/fifo_drop_writer_pkg.sv
// fifo_drop_writer_pkg: items shared between the FIFO write-side producer and the
// reader-side decoder.
//   TAG_DATA / TAG_MARK : MSB of every FIFO word; 0 = payload, 1 = drop marker
//   wr_state_e          : producer state (pass-through or dropping)
package fifo_drop_writer_pkg;

  localparam logic TAG_DATA = 1'b0;
  localparam logic TAG_MARK = 1'b1;

  typedef enum logic {
    StPass,
    StDrop
  } wr_state_e;

endpackage

// File: rtl/fifo_drop_writer_sat.sv
// sat_counter: up-counter that sticks at all-ones, with a synchronous clear.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : clear; when coinciding with inc the counter lands on 1
//   inc        : increment by one (ignored once saturated)
//   cnt        : current count
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? One : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + One;
    end
  end

endmodule

// File: rtl/fifo_drop_writer.sv
// fifo_drop_writer: write-side producer for the async FIFO. Buffers one word in an
// output register and either back-pressures upstream (drop_en=0) or discards words
// while the FIFO is blocked (drop_en=1), followed by a single marker word carrying
// the number of words lost in that run.
//   wclk, wrst_n       : write clock, asynchronous active-low reset
//   drop_en            : 1 = drop mode, 0 = lossless backpressure
//   clr_stats          : pulse; clears drop_total and ovf_sticky
//   in_valid/in_data   : upstream word; in_ready is the (combinational) accept
//   fifo_winc/wdata    : FIFO write strobe and {tag, payload}
//   fifo_wfull(_almost): FIFO full / almost-full flags
//   drop_total         : saturating count of all dropped words
//   ovf_sticky         : set on any drop, held until clr_stats
module fifo_drop_writer
  import fifo_drop_writer_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              drop_en,
  input  logic              clr_stats,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              fifo_winc,
  output logic [DATA_W:0]   fifo_wdata,
  input  logic              fifo_wfull,
  input  logic              fifo_wfull_almost,
  output logic [CNT_W-1:0]  drop_total,
  output logic              ovf_sticky
);

  localparam logic [DATA_W+1:0] MarkMax = {2'b00, {DATA_W{1'b1}}};

  wr_state_e         state;
  logic              out_vld;
  logic              out_tag;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W:0]   seg_cnt;

  logic              space;
  logic              fire;
  logic              load_ok;
  logic              load_data;
  logic              load_mark;
  logic              drop_word;
  logic              seg_inc;
  logic              seg_clr;
  logic [DATA_W+1:0] mark_sum;
  logic [DATA_W-1:0] mark_payload;

  always_comb begin
    // Almost-full gates writes too: it is registered in the FIFO, so the spare
    // entries absorb its one-cycle lag.
    space   = !fifo_wfull && !fifo_wfull_almost;
    fire    = out_vld && space;
    load_ok = !out_vld || fire;

    in_ready  = 1'b1;
    load_data = 1'b0;
    load_mark = 1'b0;
    drop_word = 1'b0;
    seg_inc   = 1'b0;
    seg_clr   = 1'b0;

    unique case (state)
      StPass: begin
        in_ready  = drop_en ? 1'b1 : load_ok;
        load_data = in_valid && load_ok;
        drop_word = drop_en && in_valid && !load_ok;
        seg_inc   = drop_word;
      end
      StDrop: begin
        // Always accept here; a word arriving as the marker loads is folded
        // into that marker rather than starting a new segment.
        in_ready  = 1'b1;
        load_mark = load_ok;
        drop_word = in_valid;
        seg_inc   = in_valid && !load_ok;
        seg_clr   = load_ok;
      end
      default: begin
        in_ready = 1'b1;
      end
    endcase

    mark_sum     = {1'b0, seg_cnt} + {{(DATA_W+1){1'b0}}, in_valid};
    mark_payload = (mark_sum > MarkMax) ? {DATA_W{1'b1}} : mark_sum[DATA_W-1:0];
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state      <= StPass;
      out_vld    <= 1'b0;
      out_tag    <= TAG_DATA;
      out_data   <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (load_data) begin
        out_vld  <= 1'b1;
        out_tag  <= TAG_DATA;
        out_data <= in_data;
      end else if (load_mark) begin
        out_vld  <= 1'b1;
        out_tag  <= TAG_MARK;
        out_data <= mark_payload;
      end else if (fire) begin
        out_vld  <= 1'b0;
      end

      unique case (state)
        StPass:  if (drop_word) state <= StDrop;
        StDrop:  if (load_mark) state <= StPass;
        default: state <= StPass;
      endcase

      // A drop in the same cycle as a clear wins so that drop is not lost.
      if (drop_word) begin
        ovf_sticky <= 1'b1;
      end else if (clr_stats) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

  assign fifo_winc  = fire;
  assign fifo_wdata = {out_tag, out_data};

  sat_counter #(
    .WIDTH(DATA_W + 1)
  ) u_seg_cnt (
    .clk  (wclk),
    .rst_n(wrst_n),
    .clr  (seg_clr),
    .inc  (seg_inc),
    .cnt  (seg_cnt)
  );

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_drop_total (
    .clk  (wclk),
    .rst_n(wrst_n),
    .clr  (clr_stats),
    .inc  (drop_word),
    .cnt  (drop_total)
  );

endmodule

// File: tb/tb_fifo_drop_writer.sv
// Directed bench for fifo_drop_writer: inputs change 2 time units after the rising
// edge, checks run 1 unit later, and FIFO writes are captured on the falling edge.
module tb_fifo_drop_writer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  logic              wclk;
  logic              wrst_n;
  logic              drop_en;
  logic              clr_stats;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              fifo_winc;
  logic [DATA_W:0]   fifo_wdata;
  logic              fifo_wfull;
  logic              fifo_wfull_almost;
  logic [CNT_W-1:0]  drop_total;
  logic              ovf_sticky;

  int errors = 0;
  int checks = 0;
  logic [DATA_W:0] wq[$];
  logic [DATA_W:0] exp_q[$];

  fifo_drop_writer #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .wclk             (wclk),
    .wrst_n           (wrst_n),
    .drop_en          (drop_en),
    .clr_stats        (clr_stats),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .fifo_winc        (fifo_winc),
    .fifo_wdata       (fifo_wdata),
    .fifo_wfull       (fifo_wfull),
    .fifo_wfull_almost(fifo_wfull_almost),
    .drop_total       (drop_total),
    .ovf_sticky       (ovf_sticky)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  always @(negedge wclk) begin
    if (fifo_winc === 1'b1) begin
      wq.push_back(fifo_wdata);
      checks++;
      assert (fifo_wfull === 1'b0) else begin
        errors++;
        $error("FAIL winc_while_full: fifo_wfull=%b required 0", fifo_wfull);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #2;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_count"}, wq.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < wq.size(); k++) begin
      chk(tag, {23'd0, wq[k]}, {23'd0, exp_q[k]});
    end
    wq.delete();
    exp_q.delete();
  endtask

  // Load one data word into the empty output register, then block the FIFO.
  task automatic load_and_block(input logic [7:0] d, input logic use_full);
    in_valid = 1'b1;
    in_data  = d;
    step();
    fifo_wfull        = use_full;
    fifo_wfull_almost = !use_full;
  endtask

  task automatic offer_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      #1;
      chk("drop_ready", {31'd0, in_ready}, 32'd1);
      step();
    end
  endtask

  task automatic pulse_clr();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
  endtask

  initial begin
    wrst_n = 1'b1;
    drop_en = 1'b0;
    clr_stats = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    fifo_wfull = 1'b0;
    fifo_wfull_almost = 1'b0;
    #1 wrst_n = 1'b0;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_winc", {31'd0, fifo_winc}, 32'd0);
    chk("rst_wdata", {23'd0, fifo_wdata}, 32'd0);
    chk("rst_drop_total", {16'd0, drop_total}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_sticky}, 32'd0);
    @(posedge wclk);
    @(posedge wclk);
    #2 wrst_n = 1'b1;
    step();

    // Lossless stream: each word appears one cycle after acceptance.
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      #1;
      chk("ll_ready", {31'd0, in_ready}, 32'd1);
      if (i > 0) begin
        chk("ll_winc", {31'd0, fifo_winc}, 32'd1);
        chk("ll_wdata", {23'd0, fifo_wdata}, 32'(i - 1));
      end
      step();
      exp_q.push_back({1'b0, 8'(i)});
    end
    in_valid = 1'b0;
    #1;
    chk("ll_last_winc", {31'd0, fifo_winc}, 32'd1);
    chk("ll_last_wdata", {23'd0, fifo_wdata}, 32'h013);
    idle(3);
    compare_writes("ll_writes");
    chk("ll_drop_total", {16'd0, drop_total}, 32'd0);

    // Backpressure: word 0x40 held for 10 cycles, 0x41 waits upstream.
    in_valid = 1'b1;
    in_data  = 8'h40;
    step();
    fifo_wfull_almost = 1'b1;
    in_data = 8'h41;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_winc", {31'd0, fifo_winc}, 32'd0);
      step();
    end
    fifo_wfull_almost = 1'b0;
    #1;
    chk("bp_resume_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_data = 8'h42;
    step();
    idle(3);
    exp_q.push_back(9'h040);
    exp_q.push_back(9'h041);
    exp_q.push_back(9'h042);
    compare_writes("bp_writes");
    chk("bp_drop_total", {16'd0, drop_total}, 32'd0);

    // Drop and marker: 5 words lost behind a held data word.
    drop_en = 1'b1;
    load_and_block(8'h55, 1'b0);
    offer_n(5, 8'h60);
    fifo_wfull_almost = 1'b0;
    idle(4);
    exp_q.push_back(9'h055);
    exp_q.push_back(9'h105);
    compare_writes("dm_writes");
    chk("dm_drop_total", {16'd0, drop_total}, 32'd5);
    chk("dm_ovf", {31'd0, ovf_sticky}, 32'd1);

    // Marker saturation: 300 drops, payload clamps at 0xFF.
    pulse_clr();
    #1;
    chk("clr_total", {16'd0, drop_total}, 32'd0);
    chk("clr_ovf", {31'd0, ovf_sticky}, 32'd0);
    load_and_block(8'h66, 1'b0);
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
    end
    fifo_wfull_almost = 1'b0;
    idle(4);
    exp_q.push_back(9'h066);
    exp_q.push_back(9'h1ff);
    compare_writes("sat_writes");
    chk("sat_drop_total", {16'd0, drop_total}, 32'd300);

    // Concurrent edge: word offered as space returns joins the marker (3+1).
    pulse_clr();
    load_and_block(8'h77, 1'b1);
    offer_n(3, 8'h80);
    fifo_wfull = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    step();
    in_data = 8'h99;
    #1;
    chk("ce_marker_winc", {31'd0, fifo_winc}, 32'd1);
    chk("ce_marker_wdata", {23'd0, fifo_wdata}, 32'h104);
    step();
    idle(3);
    exp_q.push_back(9'h077);
    exp_q.push_back(9'h104);
    exp_q.push_back(9'h099);
    compare_writes("ce_writes");
    chk("ce_drop_total", {16'd0, drop_total}, 32'd4);

    // drop_en falls while dropping: marker still goes out, then lossless.
    load_and_block(8'h11, 1'b0);
    offer_n(2, 8'h21);
    drop_en  = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("de_drop_ready", {31'd0, in_ready}, 32'd1);
    step();
    fifo_wfull_almost = 1'b0;
    step();
    fifo_wfull_almost = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h33;
    #1;
    chk("de_lossless_ready", {31'd0, in_ready}, 32'd0);
    step();
    fifo_wfull_almost = 1'b0;
    step();
    idle(3);
    exp_q.push_back(9'h011);
    exp_q.push_back(9'h102);
    exp_q.push_back(9'h033);
    compare_writes("de_writes");

    // Reset mid-DROP: nothing is written afterwards.
    drop_en = 1'b1;
    load_and_block(8'h44, 1'b0);
    offer_n(2, 8'h90);
    in_valid = 1'b0;
    drop_en  = 1'b0;
    wrst_n   = 1'b0;
    #1;
    chk("mr_ready", {31'd0, in_ready}, 32'd1);
    chk("mr_winc", {31'd0, fifo_winc}, 32'd0);
    chk("mr_wdata", {23'd0, fifo_wdata}, 32'd0);
    chk("mr_total", {16'd0, drop_total}, 32'd0);
    chk("mr_ovf", {31'd0, ovf_sticky}, 32'd0);
    step();
    wrst_n = 1'b1;
    fifo_wfull_almost = 1'b0;
    idle(4);
    compare_writes("mr_writes");

    // Clear after 7 drops, then a clear coinciding with a drop.
    drop_en = 1'b1;
    load_and_block(8'h50, 1'b0);
    offer_n(7, 8'hA0);
    fifo_wfull_almost = 1'b0;
    idle(3);
    exp_q.push_back(9'h050);
    exp_q.push_back(9'h107);
    compare_writes("c7_writes");
    chk("c7_total", {16'd0, drop_total}, 32'd7);
    chk("c7_ovf", {31'd0, ovf_sticky}, 32'd1);
    pulse_clr();
    #1;
    chk("c7_clr_total", {16'd0, drop_total}, 32'd0);
    chk("c7_clr_ovf", {31'd0, ovf_sticky}, 32'd0);
    load_and_block(8'h51, 1'b0);
    offer_n(2, 8'hB0);
    in_valid  = 1'b1;
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    fifo_wfull_almost = 1'b0;
    idle(3);
    exp_q.push_back(9'h051);
    exp_q.push_back(9'h103);
    compare_writes("cc_writes");
    chk("cc_total", {16'd0, drop_total}, 32'd1);
    chk("cc_ovf", {31'd0, ovf_sticky}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
